// File: rtl/mem_bus_master_pkg.sv
// Shared types for the shared-data-bus memory master: command opcodes, FSM states, default widths.
// No logic; used by the interface, the master and the bench.
// Opcode values match the 2-bit req_op encoding seen by the core.
package mem_bus_master_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_TA   = 3'd3,
    ST_CLR  = 3'd4,
    ST_NOP  = 3'd5
  } state_e;

  // Number of words addressed by an aw-bit address.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response and memory control signals between core, master and memory.
// Pure wiring; timing is defined by the master.
// The tri-state data bus is a separate inout net on the master, not part of this bundle.
interface mem_bus_master_if
  import mem_bus_master_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) ();

  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              done;
  logic [DWIDTH-1:0] rsp_rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_rd;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, done, rsp_rdata, mem_addr, mem_wr, mem_rd
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, done, rsp_rdata, mem_addr, mem_wr, mem_rd
  );

endinterface

// File: rtl/mem_bus_master.sv
// Bus initiator for a single-port memory with a shared tri-state data bus (READ/WRITE/CLEAR).
// Latency accept->done: WRITE 2, READ 2, CLEAR 2**AWIDTH+1, reserved op 1 cycle.
// req_ready only in IDLE; requests while busy are neither accepted nor queued.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_master_if.master  bus,
  inout  wire  [DWIDTH-1:0] mem_data
);

  localparam int D_NUM = depth_of(AWIDTH);
  // One extra bit so "all words written" is distinct from address 0.
  localparam logic [AWIDTH:0] CNT_END = (AWIDTH+1)'(D_NUM);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

  state_e            state_q,     state_d;
  logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_wr_q,    mem_wr_d;
  logic              mem_rd_q,    mem_rd_d;
  logic              drive_en_q,  drive_en_d;
  logic [DWIDTH-1:0] wdata_q,     wdata_d;
  logic              done_q,      done_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AWIDTH:0]   cnt_q,       cnt_d;

  // State and all memory-facing outputs are registered so the memory sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      drive_en_q  <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      drive_en_q  <= drive_en_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state and next register values; strobes default low, address/data hold.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    drive_en_d  = 1'b0;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_READ: begin
              state_d    = ST_RD;
              mem_addr_d = bus.req_addr;
              mem_rd_d   = 1'b1;
            end
            OP_WRITE: begin
              state_d    = ST_WR;
              mem_addr_d = bus.req_addr;
              wdata_d    = bus.req_wdata;
              mem_wr_d   = 1'b1;
              drive_en_d = 1'b1;
            end
            OP_CLEAR: begin
              state_d    = ST_CLR;
              mem_addr_d = '0;
              wdata_d    = '0;
              cnt_d      = CNT_ONE;
              mem_wr_d   = 1'b1;
              drive_en_d = 1'b1;
            end
            default: begin
              state_d = ST_NOP;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_RD: begin
        // Memory drives the bus for the whole RD cycle; capture at its end.
        state_d     = ST_TA;
        rsp_rdata_d = mem_data;
        done_d      = 1'b1;
      end
      ST_TA: begin
        // Bus stays released one cycle so the memory driver turns off before any write.
        state_d = ST_IDLE;
      end
      ST_CLR: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          mem_addr_d = cnt_q[AWIDTH-1:0];
          cnt_d      = cnt_q + CNT_ONE;
          mem_wr_d   = 1'b1;
          drive_en_d = 1'b1;
        end
      end
      ST_NOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Master drives the shared bus only in WR/CLR cycles; released otherwise.
  assign mem_data = drive_en_q ? wdata_q : {DWIDTH{1'bz}};

  assign bus.req_ready = rst_n && (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural single-port memory on the shared bus.
// Expected read data comes from a reference array and a scoreboard queue.
// Waits on the DUT are cycle-bounded; a timeout shows up as a failed comparison.
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int D_NUM = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
  wire [DW-1:0] mem_data;

  mem_bus_master #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_data (mem_data)
  );

  // Behavioural memory: latches on posedge when mem_wr, drives bus while mem_rd.
  logic [DW-1:0] mem_model [D_NUM];
  always @(posedge clk) begin
    if (bus.mem_wr) mem_model[bus.mem_addr] <= mem_data;
  end
  assign mem_data = bus.mem_rd ? mem_model[bus.mem_addr] : {DW{1'bz}};

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] ref_mem [D_NUM];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_bus = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-level invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr || bus.mem_rd)
        check("wr_rd_exclusive", 32'(bus.mem_wr && bus.mem_rd), 32'd0);
      if (bus.mem_rd)
        check("rd_bus_value", 32'(mem_data), 32'(mem_model[bus.mem_addr]));
      if (bus.mem_wr)
        check("wr_bus_value", 32'(mem_data), 32'(exp_bus));
    end
  end

  task automatic drive(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    case (op)
      OP_READ:  sb.push_back(ref_mem[a]);
      OP_WRITE: begin ref_mem[a] = wd; exp_bus = wd; end
      OP_CLEAR: exp_bus = '0;
      default: ;
    endcase
  endtask

  // Returns #1 after the posedge at which the pending request is taken.
  task automatic accept(input string tag);
    int g = 0;
    while (!bus.req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input op_e op, input int exp_lat, input string tag);
    int   lat  = 0;
    int   nwr  = 0;
    int   nrd  = 0;
    logic seen = 1'b0;
    logic [DW-1:0] e;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.mem_wr) begin
        if (op == OP_CLEAR) check({tag, "_clr_addr"}, 32'(bus.mem_addr), 32'(nwr));
        nwr++;
      end
      if (bus.mem_rd) nrd++;
      if (bus.done) seen = 1'b1;
      else check({tag, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_wr_cycles"}, 32'(nwr),
          (op == OP_WRITE) ? 32'd1 : (op == OP_CLEAR) ? 32'(D_NUM) : 32'd0);
    check({tag, "_rd_cycles"}, 32'(nrd), (op == OP_READ) ? 32'd1 : 32'd0);
    if (seen)
      check({tag, "_ready_at_done"}, 32'(bus.req_ready),
            (op == OP_WRITE || op == OP_CLEAR) ? 32'd1 : 32'd0);
    if (op == OP_READ) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(e));
      end
    end
  endtask

  task automatic issue(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int lat, input string tag);
    drive(op, a, wd);
    accept(tag);
    bus.req_valid = 1'b0;
    wait_done(op, lat, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_READ;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < D_NUM; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(bus.req_ready), 32'd0);
    check("rst_wr",     32'(bus.mem_wr),    32'd0);
    check("rst_rd",     32'(bus.mem_rd),    32'd0);
    check("rst_addr",   32'(bus.mem_addr),  32'd0);
    check("rst_done",   32'(bus.done),      32'd0);
    check("rst_rdata",  32'(bus.rsp_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.req_ready), 32'd1);

    // 1: write then read back
    issue(OP_WRITE, 5'd3, 8'hA5, 2, "t1_wr");
    issue(OP_READ,  5'd3, 8'h00, 2, "t1_rd");
    @(negedge clk);
    check("t1_rdata_hold", 32'(bus.rsp_rdata), 32'h0A5);
    check("t1_done_pulse", 32'(bus.done), 32'd0);

    // 2: clear whole memory, spot-check reads
    for (int i = 0; i < D_NUM; i++) ref_mem[i] = '0;
    issue(OP_CLEAR, 5'd0, 8'h00, D_NUM + 1, "t2_clr");
    issue(OP_READ, 5'd0,  8'h00, 2, "t2_rd0");
    issue(OP_READ, 5'd17, 8'h00, 2, "t2_rd17");
    issue(OP_READ, 5'd31, 8'h00, 2, "t2_rd31");

    // 3: back-to-back READ then WRITE to the same word with valid held
    issue(OP_WRITE, 5'd5, 8'h77, 2, "t3_pre");
    drive(OP_READ, 5'd5, 8'h00);
    accept("t3_rd");
    drive(OP_WRITE, 5'd5, 8'h3C);
    wait_done(OP_READ, 2, "t3_rd");
    accept("t3_wr");
    bus.req_valid = 1'b0;
    wait_done(OP_WRITE, 2, "t3_wr");
    issue(OP_READ, 5'd5, 8'h00, 2, "t3_rdback");

    // 4: request held during CLEAR waits until CLEAR completes
    for (int i = 0; i < D_NUM; i++) ref_mem[i] = '0;
    drive(OP_CLEAR, 5'd0, 8'h00);
    accept("t4_clr");
    drive(OP_READ, 5'd5, 8'h00);
    wait_done(OP_CLEAR, D_NUM + 1, "t4_clr");
    accept("t4_rd");
    bus.req_valid = 1'b0;
    wait_done(OP_READ, 2, "t4_rd");

    // 5: reset in the middle of CLEAR
    for (int i = 0; i < D_NUM; i++)
      issue(OP_WRITE, AW'(i), DW'(32'hC0 ^ i), 2, "t5_fill");
    drive(OP_CLEAR, 5'd0, 8'h00);
    accept("t5_clr");
    bus.req_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(bus.mem_wr && bus.mem_addr == 5'd10) && g < 100);
    check("t5_reached_10", 32'(bus.mem_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr",    32'(bus.mem_wr),    32'd0);
    check("t5_rst_rd",    32'(bus.mem_rd),    32'd0);
    check("t5_rst_addr",  32'(bus.mem_addr),  32'd0);
    check("t5_rst_done",  32'(bus.done),      32'd0);
    check("t5_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < D_NUM; i++)
      issue(OP_READ, AW'(i), 8'h00, 2, "t5_rd");

    // 6: reserved opcode
    issue(OP_RSVD, 5'd7, 8'hFF, 1, "t6_nop");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
